// File: rtl/commu_rx_inf.sv
// Serial word receiver: start bit, 16 data bits MSB first, two stop bits.
// The bit period is taken from tbit_period at each start edge and held for the whole frame.
module commu_rx_inf (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        rx,
    input  logic [19:0] tbit_period,
    output logic [15:0] data_rx,
    output logic        done_rx,
    output logic        err_rx,
    output logic        busy_rx
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_DONE, S_ERR, S_WAIT_HIGH
    } state_t;

    state_t      state_q;
    logic        rx_meta_q, rx_s_q, rx_prev_q;
    logic        rx_s;
    logic [19:0] cnt_q;
    logic [19:0] per_l_q;
    logic [3:0]  bit_cnt_q;
    logic [15:0] shreg_q;
    logic [15:0] data_q;
    logic        done_q, err_q;
    logic [19:0] half_m1, per_m1;

    assign rx_s = rx_s_q;

    // Clamp the compare points so an out-of-range period cannot underflow into a huge wait.
    assign half_m1 = (per_l_q[19:1] == 19'd0) ? 20'd0 : {1'b0, per_l_q[19:1]} - 20'd1;
    assign per_m1  = (per_l_q == 20'd0) ? 20'd0 : per_l_q - 20'd1;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            per_l_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= cnt_q + 20'd1;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_s) begin
                        state_q <= S_START;
                        per_l_q <= tbit_period;
                    end
                end
                S_START: begin
                    // Mid-start-bit check; a high line here was only a glitch.
                    if (cnt_q == half_m1) begin
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt_q == per_m1) begin
                        cnt_q     <= '0;
                        shreg_q   <= {shreg_q[14:0], rx_s};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (cnt_q == per_m1) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            data_q  <= shreg_q;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_DONE:      state_q <= S_IDLE;
                S_ERR:       state_q <= S_WAIT_HIGH;
                S_WAIT_HIGH: if (rx_s) state_q <= S_IDLE;
                default:     state_q <= S_IDLE;
            endcase
        end
    end

    assign data_rx = data_q;
    assign done_rx = done_q;
    assign err_rx  = err_q;
    assign busy_rx = (state_q != S_IDLE);

endmodule

// File: tb/tb_commu_rx_inf.sv
// Scoreboard bench for commu_rx_inf: directed frames push expected pulses, a monitor pops and checks them.
module tb_commu_rx_inf;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic [19:0] tbit_period = 20'd8;
    logic [15:0] data_rx;
    logic        done_rx, err_rx, busy_rx;

    commu_rx_inf dut (
        .clk_sys(clk_sys), .rst(rst), .rx(rx), .tbit_period(tbit_period),
        .data_rx(data_rx), .done_rx(done_rx), .err_rx(err_rx), .busy_rx(busy_rx)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit          is_err;
        logic [15:0] data;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   t_start = 0;
    int   t_done = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_pulse(input bit is_err, input logic [15:0] d);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        sbq.push_back(e);
    endtask

    // Monitor: every done/err pulse must match the head of the scoreboard.
    always @(negedge clk_sys) begin
        if (!rst && (done_rx || err_rx)) begin
            exp_t e;
            if (done_rx) t_done = cyc;
            chk("done_err_exclusive", {31'b0, done_rx & err_rx}, 32'd0);
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: done=%0b err=%0b data=%0h, nothing expected",
                         done_rx, err_rx, data_rx);
            end else begin
                e = sbq.pop_front();
                chk("pulse_is_err", {31'b0, err_rx}, {31'b0, e.is_err});
                chk("data_rx", {16'b0, data_rx}, {16'b0, e.data});
            end
        end
    end

    // Called at a negedge; returns at a negedge. abort_at<16 pulses rst mid-way through that data bit.
    // stop1=0 leaves rx low on return.
    task automatic send_frame(input logic [15:0] d, input int per, input bit stop1, input int abort_at);
        rx = 1'b0;
        t_start = cyc;
        repeat (per) @(negedge clk_sys);
        for (int i = 0; i < 16; i++) begin
            rx = d[15-i];
            if (i == abort_at) begin
                repeat (per / 2) @(negedge clk_sys);
                rst = 1'b1;
                rx  = 1'b1;
                repeat (2) @(negedge clk_sys);
                rst = 1'b0;
                return;
            end
            repeat (per) @(negedge clk_sys);
        end
        rx = stop1;
        repeat (per) @(negedge clk_sys);
        if (!stop1) return;
        rx = 1'b1;
        repeat (per) @(negedge clk_sys);
    endtask

    initial begin
        int lat;
        // Reset state
        repeat (3) @(negedge clk_sys);
        chk("rst_data", {16'b0, data_rx}, 32'd0);
        chk("rst_done", {31'b0, done_rx}, 32'd0);
        chk("rst_err", {31'b0, err_rx}, 32'd0);
        chk("rst_busy", {31'b0, busy_rx}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk_sys);
        chk("idle_busy", {31'b0, busy_rx}, 32'd0);

        // Basic frame at period 8, plus latency 2 + 4 + 17*8 = 142 (+/-1)
        tbit_period = 20'd8;
        expect_pulse(1'b0, 16'hA5C3);
        send_frame(16'hA5C3, 8, 1'b1, 99);
        repeat (20) @(negedge clk_sys);
        chk("a5c3_busy_low", {31'b0, busy_rx}, 32'd0);
        lat = t_done - t_start;
        chk("latency_window", {31'b0, (lat >= 141 && lat <= 143)}, 32'd1);

        // Back-to-back frames at period 16
        tbit_period = 20'd16;
        expect_pulse(1'b0, 16'h0000);
        expect_pulse(1'b0, 16'hFFFF);
        expect_pulse(1'b0, 16'h8001);
        send_frame(16'h0000, 16, 1'b1, 99);
        send_frame(16'hFFFF, 16, 1'b1, 99);
        send_frame(16'h8001, 16, 1'b1, 99);
        repeat (20) @(negedge clk_sys);
        chk("b2b_busy_low", {31'b0, busy_rx}, 32'd0);

        // Start glitch: 3 low cycles at period 10, no pulse expected
        tbit_period = 20'd10;
        rx = 1'b0;
        repeat (3) @(negedge clk_sys);
        rx = 1'b1;
        repeat (30) @(negedge clk_sys);
        chk("glitch_busy_low", {31'b0, busy_rx}, 32'd0);
        chk("glitch_data_kept", {16'b0, data_rx}, 32'h8001);

        // Frame error with line held low: one err, data_rx keeps 8001
        tbit_period = 20'd8;
        expect_pulse(1'b1, 16'h8001);
        send_frame(16'h1234, 8, 1'b0, 99);
        repeat (50) @(negedge clk_sys);
        chk("break_still_busy", {31'b0, busy_rx}, 32'd1);
        rx = 1'b1;
        repeat (8) @(negedge clk_sys);
        chk("break_busy_low", {31'b0, busy_rx}, 32'd0);

        // Reset during the 8th data bit, then a clean frame
        send_frame(16'h5A5A, 8, 1'b1, 7);
        repeat (10) @(negedge clk_sys);
        chk("abort_data_cleared", {16'b0, data_rx}, 32'd0);
        chk("abort_busy_low", {31'b0, busy_rx}, 32'd0);
        expect_pulse(1'b0, 16'h5A5A);
        send_frame(16'h5A5A, 8, 1'b1, 99);
        repeat (10) @(negedge clk_sys);

        // Period change mid-frame applies only to the next frame
        tbit_period = 20'd8;
        expect_pulse(1'b0, 16'hC3A5);
        expect_pulse(1'b0, 16'h0F0F);
        fork
            send_frame(16'hC3A5, 8, 1'b1, 99);
            begin
                repeat (40) @(negedge clk_sys);
                tbit_period = 20'd20;
            end
        join
        send_frame(16'h0F0F, 20, 1'b1, 99);
        repeat (30) @(negedge clk_sys);
        chk("final_busy_low", {31'b0, busy_rx}, 32'd0);
        chk("scoreboard_empty", sbq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
